// File: rtl/aes_encipher_block_p_pkg.sv
// Shared AES encipher definitions: key-length encodings, round counts, FSM
// states and the GF(2^8) helpers used by MixColumns and ShiftRows.
package aes_pkg;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_INIT = 2'd1,
        CTRL_SBOX = 2'd2,
        CTRL_MAIN = 2'd3
    } ctrl_state_t;

    // xtime over the AES field polynomial 0x11b
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // Column c occupies bits [127-32c -: 32]; row r of a column is its byte r from the top.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c + row) % 4) - 8*row -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_encipher_block_p_mixcolumn.sv
// Combinational MixColumns on one 32-bit column; every output byte is built
// from the unmixed input bytes only.
module aes_mixcolumn
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] b0, b1, b2, b3;

    assign {b0, b1, b2, b3} = col;

    assign mixed = {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                    b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                    b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                    gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};

endmodule

// File: rtl/aes_encipher_block_p.sv
// Iterative AES-128/256 encipher datapath with NUM_SBOX_WORDS words substituted
// per cycle. Define AES_ENC_ABORT_EN to add the abort input.
module aes_encipher_block_p
    import aes_pkg::*;
#(
    parameter int NUM_SBOX_WORDS = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
`ifdef AES_ENC_ABORT_EN
    input  logic                        abort,
`endif
    input  logic                        next,
    input  logic                        keylen,
    output logic [3:0]                  round,
    input  logic [127:0]                round_key,
    output logic [32*NUM_SBOX_WORDS-1:0] sboxw,
    input  logic [32*NUM_SBOX_WORDS-1:0] new_sboxw,
    input  logic [127:0]                block,
    output logic [127:0]                new_block,
    output logic                        ready
);

    localparam int N = NUM_SBOX_WORDS;
    localparam logic [1:0] WSTEP     = 2'(N);
    localparam logic [1:0] LAST_WORD = 2'(4 - N);

    generate
        if (!(N == 1 || N == 2 || N == 4)) begin : g_bad_width
            $error("NUM_SBOX_WORDS must be 1, 2 or 4");
        end
    endgenerate

    ctrl_state_t    state;
    logic [127:0]   blk_q;
    logic [3:0]     round_ctr;
    logic [1:0]     word_ctr;
    logic           keylen_q;
    logic           ready_q;

    logic [3:0]     num_rounds;
    logic           final_round;
    logic [1:0]     lane_idx [N];
    logic [32*N-1:0] sbox_lanes;
    logic [127:0]   sub_blk;
    logic [127:0]   shifted;
    logic [127:0]   mixed;
    logic [127:0]   main_blk;

    assign num_rounds  = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
    assign final_round = (round_ctr == num_rounds);

    // Lane k of the current pass works on word word_ctr+k, lane 0 in the top bits.
    generate
        for (genvar k = 0; k < N; k++) begin : g_lane
            assign lane_idx[k] = word_ctr + 2'(k);
        end
    endgenerate

    always_comb begin
        sbox_lanes = '0;
        sub_blk    = blk_q;
        for (int k = 0; k < N; k++) begin
            sbox_lanes[32*(N-1-k) +: 32]              = blk_q[32*(3 - int'(lane_idx[k])) +: 32];
            sub_blk[32*(3 - int'(lane_idx[k])) +: 32] = new_sboxw[32*(N-1-k) +: 32];
        end
    end

    assign shifted = shift_rows(blk_q);

    generate
        for (genvar c = 0; c < 4; c++) begin : g_mix
            aes_mixcolumn u_mix (
                .col   (shifted[127 - 32*c -: 32]),
                .mixed (mixed[127 - 32*c -: 32])
            );
        end
    endgenerate

    assign main_blk  = (final_round ? shifted : mixed) ^ round_key;

    assign sboxw     = (state == CTRL_SBOX) ? sbox_lanes : '0;
    assign round     = (state == CTRL_IDLE || state == CTRL_INIT) ? 4'd0 : round_ctr;
    assign new_block = blk_q;
    assign ready     = ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CTRL_IDLE;
            blk_q     <= '0;
            round_ctr <= '0;
            word_ctr  <= '0;
            keylen_q  <= AES_128_BIT_KEY;
            ready_q   <= 1'b1;
        end else begin
`ifdef AES_ENC_ABORT_EN
            if (abort && !ready_q) begin
                state     <= CTRL_IDLE;
                blk_q     <= '0;
                round_ctr <= '0;
                word_ctr  <= '0;
                ready_q   <= 1'b1;
            end else
`endif
            case (state)
                CTRL_IDLE: begin
                    if (next) begin
                        ready_q   <= 1'b0;
                        keylen_q  <= keylen;
                        round_ctr <= '0;
                        state     <= CTRL_INIT;
                    end
                end
                CTRL_INIT: begin
                    blk_q     <= block ^ round_key;
                    round_ctr <= 4'd1;
                    word_ctr  <= '0;
                    state     <= CTRL_SBOX;
                end
                CTRL_SBOX: begin
                    blk_q <= sub_blk;
                    if (word_ctr == LAST_WORD) begin
                        word_ctr <= '0;
                        state    <= CTRL_MAIN;
                    end else begin
                        word_ctr <= word_ctr + WSTEP;
                    end
                end
                CTRL_MAIN: begin
                    blk_q <= main_blk;
                    if (final_round) begin
                        ready_q <= 1'b1;
                        state   <= CTRL_IDLE;
                    end else begin
                        round_ctr <= round_ctr + 4'd1;
                        state     <= CTRL_SBOX;
                    end
                end
                default: state <= CTRL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encipher_block_p.sv
// Drives three encipher instances (1, 2 and 4 S-box words) in lockstep against a
// byte-level AES model, FIPS-197 vectors and the documented latency formula.
module tb_aes_encipher_block_p;

    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next = 1'b0;
    logic         keylen = 1'b0;
    logic [127:0] block = '0;
`ifdef AES_ENC_ABORT_EN
    logic         abort = 1'b0;
`endif

    logic [7:0]   sbox_t [256];
    logic [127:0] rk [15];
    logic         rdy [3];
    logic [127:0] nb  [3];
    logic [3:0]   rnd [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int nwf(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int NW = (g == 0) ? 1 : (g == 1) ? 2 : 4;
            logic [32*NW-1:0] sw, nsw;
            logic [3:0]       r;
            logic [127:0]     rkey, nbo;
            logic             rd;

            assign rkey = rk[r];
            always_comb begin
                nsw = '0;
                for (int b = 0; b < 4*NW; b++) nsw[8*b +: 8] = sbox_t[sw[8*b +: 8]];
            end

            aes_encipher_block_p #(.NUM_SBOX_WORDS(NW)) dut (
                .clk       (clk),
                .reset_n   (reset_n),
`ifdef AES_ENC_ABORT_EN
                .abort     (abort),
`endif
                .next      (next),
                .keylen    (keylen),
                .round     (r),
                .round_key (rkey),
                .sboxw     (sw),
                .new_sboxw (nsw),
                .block     (block),
                .new_block (nbo),
                .ready     (rd)
            );

            assign rdy[g] = rd;
            assign nb[g]  = nbo;
            assign rnd[g] = r;
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse (x^254).
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < 254; i++) p = gmul(p, x);
        return p ^ ((p << 1) | (p >> 7)) ^ ((p << 2) | (p >> 6))
                 ^ ((p << 3) | (p >> 5)) ^ ((p << 4) | (p >> 4)) ^ 8'h63;
    endfunction

    function automatic void expand(input bit k256, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk = k256 ? 8 : 4;
        nr = k256 ? 14 : 10;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                    t = t ^ {rcon, 24'h0};
                    rcon = gmul(rcon, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 15; r++)
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endfunction

    function automatic logic [127:0] encrypt(input bit k256, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        int nr;
        nr = k256 ? 14 : 10;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = s[4*((c + row) % 4) + row];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c + row] = (r < nr) ? gmul(8'h02, t[4*c + row]) ^ gmul(8'h03, t[4*c + (row+1)%4])
                                              ^ t[4*c + (row+2)%4] ^ t[4*c + (row+3)%4]
                                            : t[4*c + row];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an operation, then count edges until each instance raises ready.
    // stop_at > 0 returns right after that edge without the completion checks.
    task automatic run_op(input string tag, input bit k256, input logic [255:0] key,
                          input logic [127:0] pt, input logic [127:0] exp,
                          input bit busy, input int stop_at);
        int lat [3];
        int nr, maxr;
        logic [3:0] prev;
        bit seq_ok;
        nr = k256 ? 14 : 10;
        lat = '{0, 0, 0};
        maxr = 0; prev = 4'd0; seq_ok = 1'b1;
        expand(k256, key);
        block  = pt;
        keylen = k256;
        @(negedge clk); next = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            next = busy && (e == 5 || e == 20);
            if (busy && (e == 5 || e == 20)) keylen = ~keylen;
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++)
                if (lat[g] == 0 && rdy[g]) lat[g] = e;
            if (lat[0] == 0) begin
                if (!(rnd[0] == prev || rnd[0] == prev + 4'd1)) seq_ok = 1'b0;
                if (int'(rnd[0]) > maxr) maxr = int'(rnd[0]);
                prev = rnd[0];
            end
            if (e == stop_at) begin
                @(negedge clk); next = 1'b0;
                return;
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        @(negedge clk); next = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_lat_n%0d", tag, nwf(g)), lat[g], 1 + nr*(4/nwf(g) + 1));
            check($sformatf("%s_res_n%0d", tag, nwf(g)), nb[g], exp);
        end
        if (busy) begin
            check({tag, "_round_seq"}, seq_ok, 1'b1);
            check({tag, "_round_max"}, maxr, nr);
        end
    endtask

    initial begin
        logic [255:0] key;
        logic [127:0] pt;
        bit k256;

        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        for (int r = 0; r < 15; r++) rk[r] = '0;

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_ready_n%0d", nwf(g)), rdy[g], 1'b1);
            check($sformatf("reset_block_n%0d", nwf(g)), nb[g], 128'h0);
            check($sformatf("reset_round_n%0d", nwf(g)), rnd[g], 4'd0);
        end
        @(negedge clk); reset_n = 1'b1;

        run_op("c1", 1'b0, C1_KEY, PT, C1_CT, 1'b0, 0);
        run_op("c3", 1'b1, C3_KEY, PT, C3_CT, 1'b0, 0);
        run_op("c1_busy", 1'b0, C1_KEY, PT, C1_CT, 1'b1, 0);

        // Reset mid-operation: partial state must vanish immediately.
        run_op("c1_cut", 1'b0, C1_KEY, PT, C1_CT, 1'b0, 29);
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("midrst_ready_n%0d", nwf(g)), rdy[g], 1'b1);
            check($sformatf("midrst_block_n%0d", nwf(g)), nb[g], 128'h0);
            check($sformatf("midrst_round_n%0d", nwf(g)), rnd[g], 4'd0);
        end
        @(negedge clk); reset_n = 1'b1;
        run_op("c1_after_rst", 1'b0, C1_KEY, PT, C1_CT, 1'b0, 0);

`ifdef AES_ENC_ABORT_EN
        // next wins over abort in idle; abort later in the run clears everything.
        expand(1'b0, C1_KEY);
        block = PT; keylen = 1'b0;
        @(negedge clk); next = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++)
            check($sformatf("abort_idle_n%0d", nwf(g)), rdy[g], 1'b0);
        @(negedge clk); next = 1'b0; abort = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("abort_ready_n%0d", nwf(g)), rdy[g], 1'b1);
            check($sformatf("abort_block_n%0d", nwf(g)), nb[g], 128'h0);
        end
        @(negedge clk); abort = 1'b0;
        run_op("c1_after_abort", 1'b0, C1_KEY, PT, C1_CT, 1'b0, 0);
`endif

        for (int t = 0; t < 4; t++) begin
            k256 = 1'($urandom_range(0, 1));
            key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt   = {$urandom, $urandom, $urandom, $urandom};
            expand(k256, key);
            run_op($sformatf("rand%0d", t), k256, key, pt, encrypt(k256, pt), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_encipher_block_p.md
Name: aes_encipher_block_p

Overview:
- Iterative AES encipher datapath and control for AES-128 and AES-256.
- Generalises the single-word round logic: SubBytes lane width (words per cycle) is parametrised, and the full FSM is implemented (init, main and final rounds, round/word counters, ready handshake).
- Sits between the core top level and the shared S-box array and key memory.
- Round keys are indexed out of the block; S-box substitution is external.

Parameters:
- NUM_SBOX_WORDS, 1, number of 32-bit words substituted per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- next  in  1  start pulse; sampled only in IDLE
- keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); sampled when next is accepted
- round  out  4  round-key index requested from key memory
- round_key  in  128  key for index round, valid combinationally in the same cycle
- sboxw  out  32*NUM_SBOX_WORDS  words to the S-box array
- new_sboxw  in  32*NUM_SBOX_WORDS  substituted words, combinational return
- block  in  128  plaintext; held stable by the sender until ready rises
- new_block  out  128  state registers; valid while ready=1 after completion
- ready  out  1  idle / result valid

Behaviour:
- Reset values (async, reset_n=0): state IDLE, ready=1, round=0, word counter 0, round counter 0, keylen register 0, new_block=0.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - next=1 at an edge: ready<=0, keylen registered, round counter<=0, move to INIT.
  - next=0: stay in IDLE.
- INIT (1 edge): state <= block ^ round_key (round=0); round counter<=1; word counter<=0; move to SBOX.
- SBOX (4/NUM_SBOX_WORDS edges):
  - Pass j drives lane k (k=0 most significant) with word w[j*N+k], where w0 = new_block[127:96].
  - The same words are written back from new_sboxw.
  - The word counter increments by N and wraps to 0 after the last pass; then move to MAIN.
- MAIN (1 edge), round = round counter:
  - round counter < Nr: state <= AddRoundKey(MixColumns(ShiftRows(state))); round counter++; return to SBOX.
  - round counter == Nr: state <= AddRoundKey(ShiftRows(state)) with no MixColumns; ready<=1; move to IDLE.
- MixColumns per column uses only pre-mix bytes: {2,3,1,1} circulant over GF(2^8), polynomial 0x11b.
- sboxw = 0 outside SBOX.
- round output is 0 in IDLE and INIT, otherwise equals the round counter.
- Latency: ready rises 1 + Nr*(4/N + 1) edges after the edge that accepted next.
  - N=1: AES-128 51, AES-256 71.
  - N=4: AES-128 21, AES-256 29.
- Boundary rules:
  - next while ready=0 is ignored.
  - keylen changes during an operation are ignored.
  - new_block holds the result until the next accepted start.
  - Reset asserted mid-operation returns all registers to reset values immediately; the partial result is discarded.
  - Round counter never exceeds Nr and never wraps.

Optional Feature:
- Macro: AES_ENC_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge while ready=0 forces IDLE, ready<=1, new_block<=0 and counters to 0 on that edge.
  - abort has priority over every other transition.
  - abort in IDLE is ignored; abort and next together in IDLE mean next wins.
- Not defined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package aes_pkg:
  - keylen encodings AES_128_BIT_KEY / AES_256_BIT_KEY
  - AES128_ROUNDS = 10, AES256_ROUNDS = 14
  - FSM state encodings
  - gm2 / gm3 functions
- Sub-module aes_mixcolumn: combinational single 32-bit column MixColumns, instanced four times.

Test Plan:
- FIPS-197 C.1, N=1:
  - Stimulus: key 000102…0f, plaintext 00112233445566778899aabbccddeeff, bench models key schedule and S-box.
  - Expected: new_block = 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises exactly 51 edges after the start.
- FIPS-197 C.3 (AES-256), N=1 and N=4:
  - Stimulus: key 000102…1f, same plaintext.
  - Expected: 8ea2b7ca516745bfeafc49904b496089; latency 71 (N=1) and 29 (N=4).
- Busy-start check:
  - Stimulus: pulse next and toggle keylen at edges 5 and 20 of a C.1 run.
  - Expected: result and latency unchanged; round sequence 0,1..10 with no skips.
- Mid-operation reset:
  - Stimulus: reset_n low at edge 30 of a C.1 run, release, then start C.1 again.
  - Expected: ready=1 and new_block=0 during reset; the second run yields 69c4e0d8… in 51 edges.
- Abort (AES_ENC_ABORT_EN, N=2):
  - Stimulus: abort at edge 10 of a C.1 run, then start a fresh C.1.
  - Expected: ready=1 and new_block=0 on the next edge; fresh run completes in 31 edges with the correct result.
